// File: rtl/decode_stage.sv
// Registered decode stage for the 16-bit ISA: an output register plus one skid
// entry, with field extraction and control-flag decode driven from the output register.
module decode_stage #(
  parameter int         IW      = 16,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [3:0]    op,
  output logic [2:0]    rd,
  output logic [2:0]    rs,
  output logic [2:0]    rt,
  output logic [2:0]    funct,
  output logic [4:0]    imm5,
  output logic          use_imm,
  output logic          reg_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic          branch
  ,
  output logic          halted
);

  // Flag vector order: {use_imm, reg_write, mem_read, mem_write, branch}
  function automatic logic [4:0] flags_for(input logic [3:0] code);
    logic [4:0] f;
    f = 5'b0;
    if (code != HALT_OP) begin
      case (code)
        4'h8, 4'h9: f = 5'b11000;
        4'hA:       f = 5'b11100;
        4'hB:       f = 5'b10010;
        4'hC, 4'hD: f = 5'b10001;
        4'hE, 4'hF: f = 5'b00000;
        default:    f = 5'b01000;
      endcase
    end
    return f;
  endfunction

  logic [15:0][4:0] flag_rom;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_flag_rom
      assign flag_rom[gi] = flags_for(4'(gi));
    end
  endgenerate

  logic [IW-1:0] o_word_reg, o_word_next;
  logic          o_valid_reg, o_valid_next;
  logic [IW-1:0] s_word_reg, s_word_next;
  logic          s_valid_reg, s_valid_next;
  logic          halted_reg, halted_next;
  logic          in_ready_reg, in_ready_next;

  logic accept;
  logic o_free;

  always_comb begin
    o_word_next   = o_word_reg;
    o_valid_next  = o_valid_reg;
    s_word_next   = s_word_reg;
    s_valid_next  = s_valid_reg;
    halted_next   = halted_reg;
    accept        = in_valid & in_ready_reg;
    o_free        = ~o_valid_reg | out_ready;

    if (flush) begin
      // A word offered alongside flush is dropped and cannot trigger halt.
      o_valid_next = 1'b0;
      s_valid_next = 1'b0;
    end else begin
      if (o_free) begin
        if (s_valid_reg) begin
          o_word_next  = s_word_reg;
          o_valid_next = 1'b1;
          s_valid_next = accept;
          if (accept) begin
            s_word_next = in_instr;
          end
        end else begin
          o_valid_next = accept;
          if (accept) begin
            o_word_next = in_instr;
          end
        end
      end else if (accept) begin
        s_word_next  = in_instr;
        s_valid_next = 1'b1;
      end

      if (accept && (in_instr[15:12] == HALT_OP)) begin
        halted_next = 1'b1;
      end
    end

    in_ready_next = ~s_valid_next & ~halted_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_word_reg   <= '0;
      o_valid_reg  <= 1'b0;
      s_word_reg   <= '0;
      s_valid_reg  <= 1'b0;
      halted_reg   <= 1'b0;
      in_ready_reg <= 1'b1;
    end else begin
      o_word_reg   <= o_word_next;
      o_valid_reg  <= o_valid_next;
      s_word_reg   <= s_word_next;
      s_valid_reg  <= s_valid_next;
      halted_reg   <= halted_next;
      in_ready_reg <= in_ready_next;
    end
  end

  logic [IW-1:0] word_gated;
  logic [4:0]    flags_gated;

  // Everything reads as zero while the output register is empty.
  assign word_gated  = o_valid_reg ? o_word_reg : '0;
  assign flags_gated = o_valid_reg ? flag_rom[o_word_reg[15:12]] : 5'b0;

  assign in_ready  = in_ready_reg;
  assign out_valid = o_valid_reg;
  assign halted    = halted_reg;
  assign op        = word_gated[15:12];
  assign rd        = word_gated[11:9];
  assign rs        = word_gated[8:6];
  assign rt        = word_gated[5:3];
  assign funct     = word_gated[2:0];
  assign imm5      = word_gated[4:0];
  assign use_imm   = flags_gated[4];
  assign reg_write = flags_gated[3];
  assign mem_read  = flags_gated[2];
  assign mem_write = flags_gated[1];
  assign branch    = flags_gated[0];

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  op;
  logic [2:0]  rd, rs, rt, funct;
  logic [4:0]  imm5;
  logic        use_imm, reg_write, mem_read, mem_write, branch, halted;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.IW(16), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .op(op), .rd(rd), .rs(rs), .rt(rt),
    .funct(funct), .imm5(imm5), .use_imm(use_imm), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode straight from the ISA table.
  function automatic logic [25:0] expect_fields(input logic [15:0] w);
    logic [3:0] o;
    logic ui, rw, mr, mw, br;
    o  = w[15:12];
    ui = (o >= 4'h8) && (o <= 4'hD);
    rw = (o <= 4'hA);
    mr = (o == 4'hA);
    mw = (o == 4'hB);
    br = (o == 4'hC) || (o == 4'hD);
    return {w[15:12], w[11:9], w[8:6], w[5:3], w[2:0], w[4:0], ui, rw, mr, mw, br};
  endfunction

  // Reference model: the stage is a FIFO of at most two accepted words.
  logic [15:0] q[$];
  logic        m_halted   = 1'b0;
  logic        m_in_ready = 1'b1;
  logic        m_known    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_halted   = 1'b0;
      m_in_ready = 1'b1;
      m_known    = 1'b1;
    end else if (m_known) begin
      if (flush) begin
        q.delete();
      end else begin
        logic acc;
        acc = in_valid && m_in_ready;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          q.push_back(in_instr);
          if (in_instr[15:12] == 4'hF) m_halted = 1'b1;
        end
      end
      m_in_ready = (q.size() < 2) && !m_halted;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      check("in_ready", {31'b0, in_ready}, {31'b0, m_in_ready});
      check("halted", {31'b0, halted}, {31'b0, m_halted});
      if (q.size() != 0)
        check("fields", {6'b0, op, rd, rs, rt, funct, imm5, use_imm, reg_write, mem_read, mem_write, branch},
              {6'b0, expect_fields(q[0])});
      else
        check("idle_flags", {27'b0, use_imm, reg_write, mem_read, mem_write, branch}, 32'b0);
    end
  end

  task automatic drive(input logic v, input logic [15:0] w, input logic ordy,
                       input logic fl = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
  endtask

  initial begin
    drive(0, 16'h0, 0, 0, 1);
    drive(0, 16'h0, 0, 0, 1);
    drive(0, 16'h0, 1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_halted", {31'b0, halted}, 32'd0);

    // ADDI r2,r1,-3
    drive(1, 16'h845D, 1);
    drive(0, 16'h0, 1);
    check("addi_valid", {31'b0, out_valid}, 32'd1);
    check("addi_op", {28'b0, op}, 32'h8);
    check("addi_rd", {29'b0, rd}, 32'd2);
    check("addi_rs", {29'b0, rs}, 32'd1);
    check("addi_imm5", {27'b0, imm5}, 32'h1D);
    check("addi_flags", {27'b0, use_imm, reg_write, mem_read, mem_write, branch}, 32'b11000);

    // Back-to-back stream
    drive(1, 16'h2650, 1);
    drive(1, 16'hA442, 1);
    check("r_fields", {17'b0, op, rd, rs, rt, funct}, {17'b0, 4'h2, 3'd3, 3'd1, 3'd2, 3'd0});
    check("r_reg_write", {31'b0, reg_write}, 32'd1);
    drive(1, 16'hB442, 1);
    check("lw_mem_read", {31'b0, mem_read}, 32'd1);
    drive(0, 16'h0, 1);
    check("sw_flags", {30'b0, mem_write, use_imm}, 32'b11);
    drive(0, 16'h0, 1);

    // Back-pressure: O, S fill, third word held by fetch
    drive(1, 16'h1000, 0);
    drive(1, 16'h3000, 0);
    drive(1, 16'h5000, 0);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_head", {28'b0, op}, 32'h1);
    drive(1, 16'h5000, 0);
    drive(1, 16'h5000, 1);
    check("bp_hold_head", {28'b0, op}, 32'h1);
    drive(1, 16'h5000, 1);
    check("bp_second", {28'b0, op}, 32'h3);
    drive(0, 16'h0, 1);
    check("bp_third", {28'b0, op}, 32'h5);
    drive(0, 16'h0, 1);
    check("bp_drained", {31'b0, out_valid}, 32'd0);

    // Flush with both entries full
    drive(1, 16'h6111, 0);
    drive(1, 16'h7222, 0);
    drive(1, 16'h4333, 0, 1);
    drive(0, 16'h0, 1);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    drive(0, 16'h0, 1);
    drive(0, 16'h0, 1);

    // Halt
    drive(1, 16'hF000, 1);
    drive(1, 16'h845D, 1);
    check("halt_op", {28'b0, op}, 32'hF);
    check("halt_flags", {27'b0, use_imm, reg_write, mem_read, mem_write, branch}, 32'd0);
    check("halt_sticky", {31'b0, halted}, 32'd1);
    check("halt_in_ready", {31'b0, in_ready}, 32'd0);
    drive(1, 16'h845D, 1);
    drive(1, 16'h845D, 1);
    check("halt_blocked", {31'b0, out_valid}, 32'd0);
    drive(0, 16'h0, 1, 1);
    drive(0, 16'h0, 1);
    check("halt_after_flush", {31'b0, halted}, 32'd1);
    drive(0, 16'h0, 1, 0, 1);
    drive(0, 16'h0, 1);
    check("halt_cleared", {31'b0, halted}, 32'd0);

    // Reset while S holds a word
    drive(1, 16'h9123, 0);
    drive(1, 16'h8456, 0);
    drive(0, 16'h0, 0, 0, 1);
    drive(0, 16'h0, 1);
    check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_flags", {27'b0, use_imm, reg_write, mem_read, mem_write, branch}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] w;
      logic r, fl, v, ordy;
      w = 16'($urandom);
      if (w[15:12] == 4'hF && $urandom_range(0, 9) != 0) w[15:12] = 4'hE;
      r    = ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      v    = ($urandom_range(0, 2) != 0);
      ordy = ((i / 16) % 3 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(v, w, ordy, fl, r);
    end
    drive(0, 16'h0, 1);
    drive(0, 16'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
